// File: rtl/spi_msg_pkg.sv
// Shared types and helpers for the SPI message buffer: read FSM states,
// drop counter width and modular pointer distance.
package spi_msg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } rd_state_e;

  localparam int unsigned DROP_CNT_W = 16;

  // Distance a - b modulo 2^w.
  function automatic int unsigned ptr_dist(input int unsigned a, input int unsigned b,
                                           input int unsigned w);
    return (a - b) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/msg_len_fifo.sv
// Show-ahead FIFO of committed message lengths; head is valid whenever not empty.
module msg_len_fifo #(
  parameter int unsigned W          = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_c_o,
  output logic         full_c_o,
  output logic         empty_c_o
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  assign empty_c_o = (wr_ptr_q == rd_ptr_q);
  assign full_c_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign head_c_o  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_i && !full_c_o) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_c_o) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i && !empty_c_o) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule

// File: rtl/spi_msg_buffer.sv
// Whole-message buffer between the SPI deserializer and the consumer: speculative
// writes with rollback, length FIFO announcement, strobe-driven reads with idle gap.
module spi_msg_buffer
  import spi_msg_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH_LOG2  = 9,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned LDEPTH_LOG2 = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                  SYS_CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     IN_DATA,
  input  logic                  IN_VALID,
  input  logic                  IN_LAST,
  input  logic                  IN_ABORT,
  input  logic                  RD_REQ,
  output logic [DATA_W-1:0]     FIFO_Q,
  output logic                  GOT_FULL_MSG,
  output logic [LEN_W-1:0]      MSG_LEN,
  output logic [DROP_CNT_W-1:0] DROP_CNT,
  output logic                  OVF
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]      spec_ptr_q, spec_ptr_d;
  logic [PTR_W-1:0]      commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  dropped_q, dropped_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  ovf_q, ovf_d;

  rd_state_e             state_q;
  logic                  got_q;
  logic [LEN_W-1:0]      msg_len_q;
  logic [LEN_W-1:0]      rd_idx_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  logic [DATA_W-1:0]     fifo_q_q;

  int unsigned           used_c;
  logic                  space_ok_c;
  logic                  wr_en_c, push_c, drop_evt_c;
  logic                  rd_fire_c, last_word_c, pop_c;
  logic [LEN_W-1:0]      lf_head_c;
  logic                  lf_full_c, lf_empty_c;

  msg_len_fifo #(.W(LEN_W), .DEPTH_LOG2(LDEPTH_LOG2)) u_len_fifo (
    .clk_i       (SYS_CLK),
    .rst_i       (RST),
    .push_i      (push_c),
    .push_data_i (cnt_q + LEN_W'(1)),
    .pop_i       (pop_c),
    .head_c_o    (lf_head_c),
    .full_c_o    (lf_full_c),
    .empty_c_o   (lf_empty_c)
  );

  // Occupancy counts speculative words so a partial message reserves its space.
  assign used_c     = ptr_dist(32'(spec_ptr_q), 32'(rd_ptr_q), PTR_W);
  assign space_ok_c = !dropped_q && (used_c < DEPTH) && (cnt_q != '1);

  always_comb begin
    spec_ptr_d   = spec_ptr_q;
    commit_ptr_d = commit_ptr_q;
    cnt_d        = cnt_q;
    dropped_d    = dropped_q;
    wr_en_c      = 1'b0;
    push_c       = 1'b0;
    drop_evt_c   = 1'b0;
    if (IN_ABORT) begin
      spec_ptr_d = commit_ptr_q;
      cnt_d      = '0;
      dropped_d  = 1'b0;
      drop_evt_c = (cnt_q != '0);
    end else if (IN_VALID) begin
      if (dropped_q) begin
        if (IN_LAST) dropped_d = 1'b0;
      end else if (!space_ok_c || (IN_LAST && lf_full_c)) begin
        spec_ptr_d = commit_ptr_q;
        cnt_d      = '0;
        dropped_d  = !IN_LAST;
        drop_evt_c = 1'b1;
      end else begin
        wr_en_c    = 1'b1;
        spec_ptr_d = spec_ptr_q + PTR_W'(1);
        if (IN_LAST) begin
          push_c       = 1'b1;
          commit_ptr_d = spec_ptr_q + PTR_W'(1);
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
    end
    drop_cnt_d = (drop_evt_c && drop_cnt_q != '1) ? drop_cnt_q + DROP_CNT_W'(1) : drop_cnt_q;
    ovf_d      = ovf_q | drop_evt_c;
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      spec_ptr_q   <= '0;
      commit_ptr_q <= '0;
      cnt_q        <= '0;
      dropped_q    <= 1'b0;
      drop_cnt_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      spec_ptr_q   <= spec_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      cnt_q        <= cnt_d;
      dropped_q    <= dropped_d;
      drop_cnt_q   <= drop_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (wr_en_c) mem[spec_ptr_q[DEPTH_LOG2-1:0]] <= IN_DATA;
  end

  assign rd_fire_c   = RD_REQ && (((state_q == IDLE) && got_q) || (state_q == READ));
  assign last_word_c = (state_q == IDLE) ? (msg_len_q == LEN_W'(1))
                                         : (rd_idx_q == msg_len_q - LEN_W'(1));
  assign pop_c       = rd_fire_c && last_word_c;

  // Read FSM: announce, stream the head message, then hold off for the gap.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      got_q     <= 1'b0;
      msg_len_q <= '0;
      rd_idx_q  <= '0;
      gap_cnt_q <= '0;
      fifo_q_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      if (rd_fire_c) begin
        fifo_q_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (rd_fire_c) begin
            if (last_word_c) begin
              got_q     <= 1'b0;
              gap_cnt_q <= '0;
              state_q   <= GAP;
            end else begin
              rd_idx_q <= LEN_W'(1);
              state_q  <= READ;
            end
          end else begin
            got_q <= !lf_empty_c;
            if (!lf_empty_c) msg_len_q <= lf_head_c;
          end
        end
        READ: begin
          if (rd_fire_c) begin
            if (last_word_c) begin
              got_q     <= 1'b0;
              gap_cnt_q <= '0;
              state_q   <= GAP;
            end else begin
              rd_idx_q <= rd_idx_q + LEN_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_q <= IDLE;
          else gap_cnt_q <= gap_cnt_q + GAP_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign FIFO_Q       = fifo_q_q;
  assign GOT_FULL_MSG = got_q;
  assign MSG_LEN      = msg_len_q;
  assign DROP_CNT     = drop_cnt_q;
  assign OVF          = ovf_q;

endmodule
